// File: rtl/adma_dm_atx_split.sv
// Splits a DMA descriptor (start address, beat count, burst type) into AXI bursts that respect
// BURST_MAX, the 16-beat FIXED limit and 4 KB page boundaries.
module adma_dm_atx_split #(
    parameter int unsigned ATX_ADDR_W = 32,
    parameter int unsigned MST_ID_W   = 5,
    parameter int unsigned ATX_LEN_W  = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned XFER_W     = 16,
    parameter int unsigned BURST_MAX  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MST_ID_W-1:0]   desc_id,
    input  logic [ATX_ADDR_W-1:0] desc_addr,
    input  logic [XFER_W-1:0]     desc_beats,
    input  logic [1:0]            desc_burst,
    input  logic                  desc_vld,
    output logic                  desc_rdy,
    output logic [MST_ID_W-1:0]   atx_axid,
    output logic [ATX_ADDR_W-1:0] atx_axaddr,
    output logic [ATX_LEN_W-1:0]  atx_axlen,
    output logic [1:0]            atx_axburst,
    output logic                  atx_vld,
    input  logic                  atx_rdy,
    output logic                  desc_done
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF   = $clog2(BYTES);
    // Wide enough for both the remaining count and a full page worth of beats.
    localparam int unsigned NW    = (XFER_W + 1 > 14) ? XFER_W + 1 : 14;

    localparam logic [NW-1:0]         BMAX      = NW'(BURST_MAX);
    localparam logic [NW-1:0]         FIXED_MAX = NW'(16);
    localparam logic [ATX_ADDR_W-1:0] ADDR_MASK = ~ATX_ADDR_W'(BYTES - 1);

    typedef enum logic {StIdle, StIssue} state_e;

    state_e                state;
    logic [MST_ID_W-1:0]   cur_id;
    logic [ATX_ADDR_W-1:0] cur_addr;
    logic [XFER_W-1:0]     cur_rem;
    logic [1:0]            cur_burst;

    logic                  is_fixed;
    logic [12:0]           page_bytes;
    logic [NW-1:0]         page_beats;
    logic [NW-1:0]         rem_ext;
    logic [NW-1:0]         n;
    logic                  last;
    logic [ATX_ADDR_W-1:0] addr_step;

    assign is_fixed   = (cur_burst == 2'b00);
    assign page_bytes = 13'd4096 - {1'b0, cur_addr[11:0]};
    assign page_beats = NW'(page_bytes >> OFF);
    assign rem_ext    = NW'(cur_rem);

    always_comb begin
        n = rem_ext;
        if (is_fixed) begin
            if (n > FIXED_MAX) n = FIXED_MAX;
        end else begin
            if (n > BMAX) n = BMAX;
            if (n > page_beats) n = page_beats;
        end
    end

    assign last      = (rem_ext == n);
    assign addr_step = ATX_ADDR_W'(n) << OFF;

    assign atx_axid    = cur_id;
    assign atx_axaddr  = cur_addr;
    assign atx_axlen   = ATX_LEN_W'(n - NW'(1));
    assign atx_axburst = cur_burst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            cur_id    <= '0;
            cur_addr  <= '0;
            cur_rem   <= '0;
            cur_burst <= '0;
            atx_vld   <= 1'b0;
            desc_rdy  <= 1'b1;
            desc_done <= 1'b0;
        end else begin
            desc_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (desc_vld) begin
                        if (desc_beats != '0) begin
                            cur_id    <= desc_id;
                            cur_addr  <= desc_addr & ADDR_MASK;
                            cur_rem   <= desc_beats;
                            cur_burst <= desc_burst;
                            state     <= StIssue;
                            atx_vld   <= 1'b1;
                            desc_rdy  <= 1'b0;
                        end else begin
                            desc_done <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (atx_rdy) begin
                        cur_rem <= cur_rem - XFER_W'(n);
                        if (!is_fixed) cur_addr <= cur_addr + addr_step;
                        if (last) begin
                            state     <= StIdle;
                            atx_vld   <= 1'b0;
                            desc_rdy  <= 1'b1;
                            desc_done <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adma_dm_atx_split.sv
// Randomised and directed bench for adma_dm_atx_split, checked every cycle against a queue model
// of the expected burst sequence.
module tb_adma_dm_atx_split;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  desc_id = '0;
    logic [31:0] desc_addr = '0;
    logic [15:0] desc_beats = '0;
    logic [1:0]  desc_burst = '0;
    logic        desc_vld = 1'b0;
    logic        desc_rdy;
    logic [4:0]  atx_axid;
    logic [31:0] atx_axaddr;
    logic [7:0]  atx_axlen;
    logic [1:0]  atx_axburst;
    logic        atx_vld;
    logic        atx_rdy;
    logic        desc_done;

    adma_dm_atx_split dut (
        .clk(clk), .rst(rst),
        .desc_id(desc_id), .desc_addr(desc_addr), .desc_beats(desc_beats),
        .desc_burst(desc_burst), .desc_vld(desc_vld), .desc_rdy(desc_rdy),
        .atx_axid(atx_axid), .atx_axaddr(atx_axaddr), .atx_axlen(atx_axlen),
        .atx_axburst(atx_axburst), .atx_vld(atx_vld), .atx_rdy(atx_rdy),
        .desc_done(desc_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [4:0]  id;
        logic [1:0]  burst;
        bit          last;
    } burst_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        int          cyc;
    } hs_t;

    burst_t q[$];
    hs_t    hs_log[$];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     done_cnt = 0;
    int     done_cyc = -1;
    int     acc_cyc = -1;
    bit     done_exp = 1'b0;
    bit     rdy_mode = 1'b0;
    bit     rdy_val = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected burst list from the descriptor rules, in plain arithmetic.
    task automatic model_desc(input logic [4:0] id, input logic [31:0] addr_in,
                              input int beats, input logic [1:0] bt);
        logic [31:0] a;
        int rem, n, page;
        burst_t b;
        a = addr_in & 32'hFFFF_FFFC;
        rem = beats;
        while (rem > 0) begin
            if (bt == 2'b00) begin
                n = (rem < 16) ? rem : 16;
            end else begin
                page = (4096 - int'(a & 32'hFFF)) / 4;
                n = (rem < 256) ? rem : 256;
                if (page < n) n = page;
            end
            b.addr = a; b.len = 8'(n - 1); b.id = id; b.burst = bt; b.last = (rem == n);
            q.push_back(b);
            rem -= n;
            if (bt != 2'b00) a = a + 32'(n * 4);
        end
    endtask

    // Single driver of atx_rdy: random or held, applied just after each rising edge.
    always begin
        atx_rdy = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
        @(posedge clk);
        #2;
    end

    always @(negedge clk) begin
        bit done_nxt;
        cyc++;
        if (rst) begin
            q.delete();
            done_exp = 1'b0;
        end else begin
            done_nxt = 1'b0;
            chk("desc_done", 64'(desc_done), 64'(done_exp));
            chk("desc_rdy", 64'(desc_rdy), 64'(q.size() == 0));
            chk("atx_vld", 64'(atx_vld), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("atx_axaddr", 64'(atx_axaddr), 64'(q[0].addr));
                chk("atx_axlen", 64'(atx_axlen), 64'(q[0].len));
                chk("atx_axid", 64'(atx_axid), 64'(q[0].id));
                chk("atx_axburst", 64'(atx_axburst), 64'(q[0].burst));
                if (atx_rdy) begin
                    hs_log.push_back('{q[0].addr, q[0].len, q[0].burst, cyc});
                    done_nxt = q[0].last;
                    void'(q.pop_front());
                end
            end else if (desc_vld) begin
                acc_cyc = cyc;
                model_desc(desc_id, desc_addr, int'(desc_beats), desc_burst);
                if (desc_beats == 0) done_nxt = 1'b1;
            end
            if (desc_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            done_exp = done_nxt;
        end
    end

    task automatic send_desc(input logic [4:0] id, input logic [31:0] addr,
                             input int beats, input logic [1:0] bt);
        bit acc = 1'b0;
        desc_id = id; desc_addr = addr; desc_beats = 16'(beats); desc_burst = bt;
        desc_vld = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (desc_rdy) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        desc_vld = 1'b0;
        if (!acc) begin
            failures++;
            $display("FAIL desc_accept_timeout actual=0 expected=1");
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (desc_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        if (!ok) begin
            failures++;
            $display("FAIL idle_timeout actual=0 expected=1");
        end
    endtask

    task automatic clear_logs();
        hs_log.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic chk_hs(input int idx, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] bt);
        if (hs_log.size() <= idx) begin
            chk("hs_missing", 64'(hs_log.size()), 64'(idx + 1));
        end else begin
            chk("hs_addr", 64'(hs_log[idx].addr), 64'(addr));
            chk("hs_len", 64'(hs_log[idx].len), 64'(len));
            chk("hs_burst", 64'(hs_log[idx].burst), 64'(bt));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_desc_rdy", 64'(desc_rdy), 64'd1);
        chk("rst_atx_vld", 64'(atx_vld), 64'd0);
        chk("rst_desc_done", 64'(desc_done), 64'd0);
        @(posedge clk);
        #1;

        // 300 beats from a page start, ready held high
        rdy_val = 1'b1;
        clear_logs();
        send_desc(5'd3, 32'h1000, 300, 2'b01);
        wait_idle();
        chk("incr300_count", 64'(hs_log.size()), 64'd2);
        chk_hs(0, 32'h1000, 8'd255, 2'b01);
        chk_hs(1, 32'h1400, 8'd43, 2'b01);
        if (hs_log.size() == 2) begin
            chk("incr300_b2b", 64'(hs_log[1].cyc - hs_log[0].cyc), 64'd1);
            chk("incr300_done_cyc", 64'(done_cyc - hs_log[1].cyc), 64'd1);
        end
        chk("incr300_done_cnt", 64'(done_cnt), 64'd1);

        // 4 KB boundary split
        clear_logs();
        send_desc(5'd7, 32'h0FF0, 10, 2'b01);
        wait_idle();
        chk("page_count", 64'(hs_log.size()), 64'd2);
        chk_hs(0, 32'h0FF0, 8'd3, 2'b01);
        chk_hs(1, 32'h1000, 8'd5, 2'b01);

        // FIXED bursts cap at 16 and keep the address
        clear_logs();
        send_desc(5'd1, 32'h2000, 40, 2'b00);
        wait_idle();
        chk("fixed_count", 64'(hs_log.size()), 64'd3);
        chk_hs(0, 32'h2000, 8'd15, 2'b00);
        chk_hs(1, 32'h2000, 8'd15, 2'b00);
        chk_hs(2, 32'h2000, 8'd7, 2'b00);

        // Stall the first burst for 5 cycles
        clear_logs();
        rdy_val = 1'b0;
        send_desc(5'd2, 32'h1000, 300, 2'b01);
        repeat (5) begin
            @(negedge clk);
            chk("stall_vld", 64'(atx_vld), 64'd1);
            chk("stall_addr", 64'(atx_axaddr), 64'h1000);
            chk("stall_len", 64'(atx_axlen), 64'd255);
        end
        @(posedge clk);
        #1;
        rdy_val = 1'b1;
        wait_idle();
        chk("stall_count", 64'(hs_log.size()), 64'd2);
        chk_hs(0, 32'h1000, 8'd255, 2'b01);
        chk_hs(1, 32'h1400, 8'd43, 2'b01);

        // Empty descriptor
        clear_logs();
        send_desc(5'd4, 32'h5000, 0, 2'b01);
        wait_idle();
        chk("zero_count", 64'(hs_log.size()), 64'd0);
        chk("zero_done_cnt", 64'(done_cnt), 64'd1);
        chk("zero_done_cyc", 64'(done_cyc - acc_cyc), 64'd1);

        // Reset after the first of three bursts
        clear_logs();
        rdy_val = 1'b0;
        send_desc(5'd5, 32'h3000, 40, 2'b00);
        rdy_val = 1'b1;
        @(posedge clk);
        #1;
        rdy_val = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_vld", 64'(atx_vld), 64'd0);
        chk("rst_mid_rdy", 64'(desc_rdy), 64'd1);
        chk("rst_mid_hs", 64'(hs_log.size()), 64'd1);
        @(posedge clk);
        #1;
        chk("rst_mid_done", 64'(done_cnt), 64'd0);
        clear_logs();
        rdy_val = 1'b1;
        send_desc(5'd6, 32'h0FF0, 10, 2'b01);
        wait_idle();
        chk("rst_after_count", 64'(hs_log.size()), 64'd2);
        chk_hs(0, 32'h0FF0, 8'd3, 2'b01);
        chk_hs(1, 32'h1000, 8'd5, 2'b01);

        // Random descriptors with random backpressure
        rdy_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            int beats;
            a = $urandom;
            if ($urandom_range(0, 2) == 0) a[11:0] = 12'(4096 - 4 * $urandom_range(1, 20));
            case ($urandom_range(0, 3))
                0: beats = 0;
                1: beats = $urandom_range(1, 20);
                default: beats = $urandom_range(1, 600);
            endcase
            send_desc(5'($urandom), a, beats, 2'($urandom));
        end
        wait_idle();
        rdy_mode = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
